// File: rtl/l2_cache_pkg.sv
// Shared types for the direct-mapped L2: controller state encoding and address width.
// Pure declarations; no logic, no latency, no flow control.
package l2_cache_pkg;

    localparam int l2_addr_w = 32;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FETCH
    } l2_state_t;

endpackage

// File: rtl/l2_cache_dm_if.sv
// Arbiter-side l2_* request bus and memory-side pmem_* line bus bundled together.
// Slave = the cache; master = arbiter plus physical memory. Read/resp handshake, requests held until resp.
interface l2_cache_dm_if #(
    parameter int s_line = 256
);
    logic              l2_read;
    logic              l2_write;
    logic [31:0]       l2_address;
    logic [s_line-1:0] l2_wdata;
    logic              l2_resp;
    logic [s_line-1:0] l2_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [s_line-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [s_line-1:0] pmem_rdata;

    modport slave (
        input  l2_read, l2_write, l2_address, l2_wdata, pmem_resp, pmem_rdata,
        output l2_resp, l2_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output l2_read, l2_write, l2_address, l2_wdata, pmem_resp, pmem_rdata,
        input  l2_resp, l2_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/l2_array.sv
// Per-line storage: combinational read of the addressed entry, synchronous write when load is high.
// No reset and no flow control; the controller owns valid bits and write timing.
module l2_array #(
    parameter int width   = 1,
    parameter int s_index = 4
) (
    input  logic               clk,
    input  logic               load,
    input  logic [s_index-1:0] index,
    input  logic [width-1:0]   din,
    output logic [width-1:0]   dout
);

    logic [width-1:0] mem [2**s_index];

    always_ff @(posedge clk) begin
        if (load) begin
            mem[index] <= din;
        end
    end

    assign dout = mem[index];

endmodule

// File: rtl/l2_cache_dm.sv
// Direct-mapped write-back/write-allocate L2: hit responds one cycle after IDLE sees the request,
// miss adds writeback and fetch; requester holds its request until l2_resp, memory holds until pmem_resp.
module l2_cache_dm
    import l2_cache_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_index  = 4
) (
    input logic           clk,
    input logic           rst,
    l2_cache_dm_if.slave  bus
);

    localparam int s_tag  = l2_addr_w - s_offset - s_index;
    localparam int s_mask = 2**s_offset;
    localparam int s_line = 8 * s_mask;
    localparam int lines  = 2**s_index;

    l2_state_t          state;
    logic [lines-1:0]   valid;
    logic [lines-1:0]   dirty;

    logic [s_index-1:0] idx;
    logic [s_tag-1:0]   tag;
    logic [s_tag-1:0]   tag_rd;
    logic [s_line-1:0]  data_rd;
    logic [s_line-1:0]  data_din;
    logic               hit;
    logic               rd_req;
    logic               wr_req;
    logic               victim_dirty;
    logic               fill;
    logic               wr_commit;
    logic               load;
    logic [31:0]        fetch_addr;
    logic [31:0]        wb_addr;
    logic               unused_offset;

    assign idx          = bus.l2_address[s_offset +: s_index];
    assign tag          = bus.l2_address[31 -: s_tag];
    assign hit          = valid[idx] && (tag_rd == tag);
    assign rd_req       = bus.l2_read;
    assign wr_req       = bus.l2_write && !bus.l2_read;
    assign victim_dirty = valid[idx] && dirty[idx];
    assign fetch_addr   = {bus.l2_address[31:s_offset], {s_offset{1'b0}}};
    assign wb_addr      = {tag_rd, idx, {s_offset{1'b0}}};
    assign unused_offset = ^bus.l2_address[s_offset-1:0];

    // Arrays are written either by a line fill or by a committed full-line write in CHECK.
    assign fill      = (state == FETCH) && bus.pmem_resp;
    assign wr_commit = (state == CHECK) && bus.l2_resp && wr_req;
    assign load      = fill || wr_commit;
    assign data_din  = fill ? bus.pmem_rdata : bus.l2_wdata;

    l2_array #(.width(s_line), .s_index(s_index)) u_data (
        .clk   (clk),
        .load  (load),
        .index (idx),
        .din   (data_din),
        .dout  (data_rd)
    );

    l2_array #(.width(s_tag), .s_index(s_index)) u_tag (
        .clk   (clk),
        .load  (load),
        .index (idx),
        .din   (tag),
        .dout  (tag_rd)
    );

    assign bus.l2_rdata   = data_rd;
    assign bus.pmem_wdata = data_rd;

    // l2_resp is decided on entry to CHECK so it can be a registered one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            valid            <= '0;
            dirty            <= '0;
            bus.l2_resp      <= 1'b0;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        state       <= CHECK;
                        bus.l2_resp <= hit || (wr_req && !victim_dirty);
                    end
                end
                CHECK: begin
                    if (bus.l2_resp) begin
                        bus.l2_resp <= 1'b0;
                        state       <= IDLE;
                        if (wr_req) begin
                            valid[idx] <= 1'b1;
                            dirty[idx] <= 1'b1;
                        end
                    end else if (victim_dirty) begin
                        state            <= WRITEBACK;
                        bus.pmem_write   <= 1'b1;
                        bus.pmem_address <= wb_addr;
                    end else begin
                        state            <= FETCH;
                        bus.pmem_read    <= 1'b1;
                        bus.pmem_address <= fetch_addr;
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        bus.pmem_write <= 1'b0;
                        dirty[idx]     <= 1'b0;
                        if (rd_req) begin
                            state            <= FETCH;
                            bus.pmem_read    <= 1'b1;
                            bus.pmem_address <= fetch_addr;
                        end else begin
                            state            <= CHECK;
                            bus.l2_resp      <= 1'b1;
                            bus.pmem_address <= '0;
                        end
                    end
                end
                FETCH: begin
                    if (bus.pmem_resp) begin
                        bus.pmem_read    <= 1'b0;
                        bus.pmem_address <= '0;
                        valid[idx]       <= 1'b1;
                        dirty[idx]       <= 1'b0;
                        state            <= CHECK;
                        bus.l2_resp      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_cache_dm.sv
// Directed bench for l2_cache_dm with a behavioural physical memory that answers two cycles late.
module tb_l2_cache_dm;
    import l2_cache_pkg::*;

    localparam logic [255:0] LA = {8{32'hA0A0_0040}};
    localparam logic [255:0] LB = {8{32'hB0B0_0100}};
    localparam logic [255:0] LC = {8{32'hC0C0_0300}};
    localparam logic [255:0] LD = {8{32'hD0D0_0300}};
    localparam logic [255:0] LE = {8{32'hE0E0_0500}};
    localparam logic [255:0] LF = {8{32'hF0F0_0060}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_cache_dm_if #(.s_line(256)) bus ();

    l2_cache_dm #(.s_offset(5), .s_index(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [255:0] mem_model [logic [31:0]];
    int n_rd = 0, n_wr = 0, seq = 0, rd_stamp = 0, wr_stamp = 0;
    int excl_err = 0, resp_cnt = 0, req_cnt = 0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_wr_addr = '0;
    logic [255:0] last_wr_data = '0;
    bit hold_mem = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {8{a ^ 32'h5A5A_5A5A}};
    endfunction

    // Physical memory: notices a request, waits two cycles, pulses pmem_resp for one cycle.
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && !hold_mem && (bus.pmem_read || bus.pmem_write)) begin
                repeat (2) @(negedge clk);
                seq++;
                if (bus.pmem_write) begin
                    n_wr++;
                    wr_stamp     = seq;
                    last_wr_addr = bus.pmem_address;
                    last_wr_data = bus.pmem_wdata;
                    mem_model[bus.pmem_address] = bus.pmem_wdata;
                end else begin
                    n_rd++;
                    rd_stamp       = seq;
                    last_rd_addr   = bus.pmem_address;
                    bus.pmem_rdata = mem_line(bus.pmem_address);
                end
                bus.pmem_resp = 1'b1;
                @(negedge clk);
                bus.pmem_resp = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.pmem_read && bus.pmem_write) excl_err++;
        if (bus.l2_resp) resp_cnt++;
    end

    // Called just after a rising edge; returns just after the edge that closes the resp cycle.
    task automatic l2_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wd, output logic [255:0] rdat, output int lat);
        bit done;
        done           = 1'b0;
        lat            = 0;
        rdat           = '0;
        req_cnt++;
        bus.l2_read    = rd;
        bus.l2_write   = wr;
        bus.l2_address = addr;
        bus.l2_wdata   = wd;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.l2_resp) begin
                done = 1'b1;
                rdat = bus.l2_rdata;
            end
        end
        if (!done) check("resp_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.l2_read  = 1'b0;
        bus.l2_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] rd;
        int lat, rd0, wr0, t;
        rst            = 1'b1;
        bus.l2_read    = 1'b0;
        bus.l2_write   = 1'b0;
        bus.l2_address = '0;
        bus.l2_wdata   = '0;
        mem_model[32'h40]  = LA;
        mem_model[32'h300] = LC;

        repeat (3) @(negedge clk);
        check("rst_l2_resp", bus.l2_resp, 0);
        check("rst_pmem_read", bus.pmem_read, 0);
        check("rst_pmem_write", bus.pmem_write, 0);
        check("rst_pmem_addr", bus.pmem_address, 0);
        check("rst_state", dut.state, IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold read, then re-read hits with no memory traffic.
        l2_req(1, 0, 32'h40, '0, rd, lat);
        check("cold_rdata", rd, LA);
        check("cold_n_rd", n_rd, 1);
        check("cold_rd_addr", last_rd_addr, 32'h40);
        check("cold_n_wr", n_wr, 0);
        l2_req(1, 0, 32'h40, '0, rd, lat);
        check("hit_rdata", rd, LA);
        check("hit_lat", lat, 1);
        check("hit_n_rd", n_rd, 1);

        // Write miss on invalid line completes in CHECK, then reads back.
        l2_req(0, 1, 32'h100, LB, rd, lat);
        check("wmiss_lat", lat, 1);
        check("wmiss_n_rd", n_rd, 1);
        check("wmiss_n_wr", n_wr, 0);
        l2_req(1, 0, 32'h100, '0, rd, lat);
        check("wb_hit_rdata", rd, LB);
        check("wb_hit_lat", lat, 1);

        // Dirty conflict at index 8: writeback 0x100 then fetch 0x300.
        l2_req(1, 0, 32'h300, '0, rd, lat);
        check("conf_n_wr", n_wr, 1);
        check("conf_wr_addr", last_wr_addr, 32'h100);
        check("conf_wr_data", last_wr_data, LB);
        check("conf_rd_addr", last_rd_addr, 32'h300);
        check("conf_order", wr_stamp < rd_stamp, 1);
        check("conf_rdata", rd, LC);

        // Write miss over a dirty line: writeback only, no fetch.
        l2_req(0, 1, 32'h300, LD, rd, lat);
        check("dirty_hit_lat", lat, 1);
        rd0 = n_rd;
        l2_req(0, 1, 32'h500, LE, rd, lat);
        check("wdirty_n_wr", n_wr, 2);
        check("wdirty_wr_addr", last_wr_addr, 32'h300);
        check("wdirty_wr_data", last_wr_data, LD);
        check("wdirty_no_fetch", n_rd, rd0);
        l2_req(1, 0, 32'h500, '0, rd, lat);
        check("wdirty_rdata", rd, LE);
        check("wdirty_hit_lat", lat, 1);

        // Evicting 0x500 and refetching 0x100 returns the line written back earlier.
        l2_req(1, 0, 32'h100, '0, rd, lat);
        check("refetch_rdata", rd, LB);
        check("refetch_wr_addr", last_wr_addr, 32'h500);
        check("refetch_wr_data", last_wr_data, LE);

        // Reset during a fetch with memory silent.
        rd0            = n_rd;
        hold_mem       = 1'b1;
        bus.l2_address = 32'h80;
        bus.l2_read    = 1'b1;
        t = 0;
        while (!bus.pmem_read && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("fetch_started", bus.pmem_read, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_pmem_read", bus.pmem_read, 0);
        check("midrst_state", dut.state, IDLE);
        check("midrst_resp", bus.l2_resp, 0);
        bus.l2_read = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        hold_mem = 1'b0;
        check("midrst_no_rd", n_rd, rd0);
        wr0 = n_wr;
        l2_req(1, 0, 32'h40, '0, rd, lat);
        check("postrst_miss_rd", n_rd, rd0 + 1);
        check("postrst_rd_addr", last_rd_addr, 32'h40);
        check("postrst_rdata", rd, LA);
        check("postrst_lat_gt1", lat > 1, 1);
        check("postrst_no_wb", n_wr, wr0);

        // Back-to-back I-read and D-write, each its own pulse.
        l2_req(1, 0, 32'h40, '0, rd, lat);
        check("il_i_rdata", rd, LA);
        l2_req(0, 1, 32'h60, LF, rd, lat);
        check("il_d_lat", lat, 1);
        l2_req(1, 0, 32'h60, '0, rd, lat);
        check("il_d_rdata", rd, LF);

        repeat (2) @(negedge clk);
        check("resp_pulses", resp_cnt, req_cnt);
        check("pmem_excl", excl_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
